// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with four operating modes:
// LEVEL (registered decode), PULSE (strobe on load), SCAN (walking one-hot
// sequencer with wrap pulse) and STICKY (OR-accumulated select mask).
// Every output comes from a flop, so select fabrics see glitch-free edges.
module decoder_nto2n_seq #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     i,
    input  logic             load,
    input  logic             clr,
    output logic [2**N-1:0]  y,
    output logic [N-1:0]     idx,
    output logic             wrap
);

    localparam int W = 2**N;

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_STICKY = 2'b11
    } mode_t;

    mode_t          mode_q;
    logic [N-1:0]   idx_inc;

    // One-hot decode of a binary index.
    function automatic logic [W-1:0] onehot(input logic [N-1:0] v);
        onehot    = '0;
        onehot[v] = 1'b1;
    endfunction

    // Next scan position; the N-bit width makes 2^N-1 roll over to 0.
    assign idx_inc = idx + 1'b1;

    // Mode register and all output registers; priority rst > clr > mode change > en=0 > mode action.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            y      <= '0;
            idx    <= '0;
            wrap   <= 1'b0;
            mode_q <= MODE_LEVEL;
        end else begin
            // NOTE: wrap gets a default here so it is a one-cycle pulse;
            // only the SCAN increment branch below overrides it.
            wrap   <= 1'b0;
            mode_q <= mode_t'(mode);

            if (clr) begin
                y   <= '0;
                idx <= '0;
            end else if (mode != mode_q) begin
                // Transition edge: flush state, the new mode acts from the next edge.
                y   <= '0;
                idx <= '0;
            end else if (!en) begin
                // STICKY keeps its mask while disabled; other modes go quiet.
                if (mode_q != MODE_STICKY) begin
                    y <= '0;
                end
            end else begin
                unique case (mode_q)
                    MODE_LEVEL: begin
                        y   <= onehot(i);
                        idx <= i;
                    end
                    MODE_PULSE: begin
                        if (load) begin
                            y   <= onehot(i);
                            idx <= i;
                        end else begin
                            y <= '0;
                        end
                    end
                    MODE_SCAN: begin
                        if (load) begin
                            y   <= onehot(i);
                            idx <= i;
                        end else begin
                            y    <= onehot(idx_inc);
                            idx  <= idx_inc;
                            wrap <= (idx == '1);
                        end
                    end
                    MODE_STICKY: begin
                        if (load) begin
                            y   <= y | onehot(i);
                            idx <= i;
                        end
                    end
                    default: begin
                        y <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench for decoder_nto2n_seq. Two instances (N=3 and N=4)
// share the control inputs; a behavioural model built from plain integer
// arithmetic predicts y/idx/wrap for both, and directed steps also compare
// against hand-derived constants.
module tb_decoder_nto2n_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        load;
    logic        clr;
    logic [2:0]  i3;
    logic [3:0]  i4;

    logic [7:0]  y3;
    logic [2:0]  idx3;
    logic        wrap3;
    logic [15:0] y4;
    logic [3:0]  idx4;
    logic        wrap4;

    int n_cmp = 0;
    int n_err = 0;

    // Model state per instance (0: N=3, 1: N=4).
    int unsigned m_y    [2];
    int          m_idx  [2];
    int          m_wrap [2];
    int          m_mode [2];

    decoder_nto2n_seq #(.N(3)) dut3 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .i    (i3),
        .load (load),
        .clr  (clr),
        .y    (y3),
        .idx  (idx3),
        .wrap (wrap3)
    );

    decoder_nto2n_seq #(.N(4)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .i    (i4),
        .load (load),
        .clr  (clr),
        .y    (y4),
        .idx  (idx4),
        .wrap (wrap4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one instance of width n, applied at a clock edge.
    task automatic model_step(input int k, input int n, input int iv);
        int size;
        size = 1 << n;
        if (rst) begin
            m_y[k] = 0; m_idx[k] = 0; m_wrap[k] = 0; m_mode[k] = 0;
            return;
        end
        m_wrap[k] = 0;
        if (clr) begin
            m_y[k] = 0; m_idx[k] = 0; m_mode[k] = int'(mode);
        end else if (int'(mode) != m_mode[k]) begin
            m_y[k] = 0; m_idx[k] = 0; m_mode[k] = int'(mode);
        end else if (!en) begin
            if (m_mode[k] != 3) m_y[k] = 0;
        end else begin
            case (m_mode[k])
                0: begin m_y[k] = 1 << iv; m_idx[k] = iv; end
                1: begin
                    if (load) begin m_y[k] = 1 << iv; m_idx[k] = iv; end
                    else m_y[k] = 0;
                end
                2: begin
                    if (load) begin
                        m_y[k] = 1 << iv; m_idx[k] = iv;
                    end else begin
                        if (m_idx[k] == size - 1) m_wrap[k] = 1;
                        m_idx[k] = (m_idx[k] + 1) % size;
                        m_y[k]   = 1 << m_idx[k];
                    end
                end
                default: begin
                    if (load) begin m_y[k] = m_y[k] | (1 << iv); m_idx[k] = iv; end
                end
            endcase
        end
    endtask

    // Advance one clock, update the model at the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step(0, 3, int'(i3));
        model_step(1, 4, int'(i4));
        @(negedge clk);
        check("y3",    32'(y3),    m_y[0]);
        check("idx3",  32'(idx3),  32'(m_idx[0]));
        check("wrap3", 32'(wrap3), 32'(m_wrap[0]));
        check("y4",    32'(y4),    m_y[1]);
        check("idx4",  32'(idx4),  32'(m_idx[1]));
        check("wrap4", 32'(wrap4), 32'(m_wrap[1]));
    endtask

    // Compare the N=3 instance against hand-derived constants.
    task automatic expect3(input string tag, input logic [7:0] ey, input logic [2:0] eidx, input logic ewrap);
        check({tag, ".y"},    32'(y3),    32'(ey));
        check({tag, ".idx"},  32'(idx3),  32'(eidx));
        check({tag, ".wrap"}, 32'(wrap3), 32'(ewrap));
    endtask

    task automatic set_i(input int v);
        i3 = 3'(v);
        i4 = 4'(v);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; clr = 1'b0;
        set_i(0);
        foreach (m_y[k]) begin m_y[k] = 0; m_idx[k] = 0; m_wrap[k] = 0; m_mode[k] = 0; end

        // Reset for two cycles.
        cycle(); cycle();
        expect3("reset", 8'h00, 3'd0, 1'b0);

        // LEVEL decode, then disable.
        rst = 1'b0; en = 1'b1; set_i(5);
        cycle(); expect3("level_i5", 8'h20, 3'd5, 1'b0);
        en = 1'b0;
        cycle(); expect3("level_en0", 8'h00, 3'd5, 1'b0);

        // PULSE: transition edge, single strobe, held strobes.
        en = 1'b1; mode = 2'b01;
        cycle(); expect3("pulse_trans", 8'h00, 3'd0, 1'b0);
        load = 1'b1; set_i(3);
        cycle(); expect3("pulse_i3", 8'h08, 3'd3, 1'b0);
        load = 1'b0;
        cycle(); expect3("pulse_off", 8'h00, 3'd3, 1'b0);
        load = 1'b1; set_i(1);
        cycle(); expect3("pulse_h1", 8'h02, 3'd1, 1'b0);
        set_i(2);
        cycle(); expect3("pulse_h2", 8'h04, 3'd2, 1'b0);
        set_i(7);
        cycle(); expect3("pulse_h7", 8'h80, 3'd7, 1'b0);

        // SCAN: load 6, walk through the wrap.
        load = 1'b0; mode = 2'b10;
        cycle(); expect3("scan_trans", 8'h00, 3'd0, 1'b0);
        load = 1'b1; set_i(6);
        cycle(); expect3("scan_ld6", 8'h40, 3'd6, 1'b0);
        load = 1'b0;
        cycle(); expect3("scan_7", 8'h80, 3'd7, 1'b0);
        cycle(); expect3("scan_wrap", 8'h01, 3'd0, 1'b1);
        cycle(); expect3("scan_1", 8'h02, 3'd1, 1'b0);

        // SCAN pause and resume.
        en = 1'b0;
        cycle(); expect3("scan_pause1", 8'h00, 3'd1, 1'b0);
        cycle(); expect3("scan_pause2", 8'h00, 3'd1, 1'b0);
        en = 1'b1;
        cycle(); expect3("scan_resume", 8'h04, 3'd2, 1'b0);

        // STICKY accumulation, hold, clear.
        mode = 2'b11;
        cycle(); expect3("sticky_trans", 8'h00, 3'd0, 1'b0);
        load = 1'b1;
        set_i(0); cycle(); expect3("sticky_0", 8'h01, 3'd0, 1'b0);
        set_i(4); cycle(); expect3("sticky_4", 8'h11, 3'd4, 1'b0);
        set_i(4); cycle(); expect3("sticky_4b", 8'h11, 3'd4, 1'b0);
        set_i(7); cycle(); expect3("sticky_7", 8'h91, 3'd7, 1'b0);
        load = 1'b0; en = 1'b0;
        cycle(); expect3("sticky_hold", 8'h91, 3'd7, 1'b0);
        en = 1'b1; clr = 1'b1;
        cycle(); expect3("sticky_clr", 8'h00, 3'd0, 1'b0);
        clr = 1'b0; load = 1'b1;
        set_i(0); cycle();
        set_i(4); cycle();
        set_i(7); cycle(); expect3("sticky_refill", 8'h91, 3'd7, 1'b0);

        // Mode change out of STICKY, then LEVEL decode.
        load = 1'b0; mode = 2'b00; set_i(2);
        cycle(); expect3("sticky_to_level", 8'h00, 3'd0, 1'b0);
        cycle(); expect3("level_i2", 8'h04, 3'd2, 1'b0);

        // Reset while scanning; mode_q must return to LEVEL.
        mode = 2'b10;
        cycle(); cycle(); cycle();
        expect3("scan_run", 8'h04, 3'd2, 1'b0);
        rst = 1'b1;
        cycle(); expect3("scan_rst", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        cycle(); expect3("post_rst_trans", 8'h00, 3'd0, 1'b0);

        // N=4 LEVEL top index.
        mode = 2'b00;
        cycle();
        i4 = 4'd15; i3 = 3'd7;
        cycle();
        check("n4_level15.y", 32'(y4), 32'h8000);
        check("n4_level15.idx", 32'(idx4), 32'd15);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 59) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 11) == 0) mode = 2'($urandom());
            en   = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 2) == 0);
            i4   = 4'($urandom());
            i3   = i4[2:0];
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
